uart_rx_ctrl: RTL and testbench

Receive-side controller placed directly after the serial-in/parallel-out frame assembler of the UART receiver. It detects each completed 11-bit frame, checks the start, parity and stop bits, and stores valid data bytes in a small FIFO with a read handshake. It also keeps sticky error status (parity, framing, overrun) for the host.

---
 rtl/uart_rx_ctrl_if.sv | 33 +++
 rtl/uart_rx_ctrl.sv | 127 ++++++++++++
 tb/tb_uart_rx_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - assembler/host side signal bundle for the UART receive controller
interface uart_rx_ctrl_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          active_flag;
    logic          recieved_flag;
    logic [10:0]   data_parll;
    logic          rd_en;
    logic          err_clr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;
    logic          rx_busy;

    modport slave (
        input  active_flag, recieved_flag, data_parll, rd_en, err_clr,
        output rd_data, rd_valid, fifo_empty, fifo_full, fifo_count,
               parity_err, frame_err, overrun_err, rx_busy
    );

    modport master (
        output active_flag, recieved_flag, data_parll, rd_en, err_clr,
        input  rd_data, rd_valid, fifo_empty, fifo_full, fifo_count,
               parity_err, frame_err, overrun_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART frame checker with byte FIFO and sticky error status
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_ODD  = 0,
    parameter int DROP_ON_ERR = 1
) (
    input  logic           baud_clk,
    input  logic           reset,
    uart_rx_ctrl_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic ODD_BIT  = (PARITY_ODD != 0);
    localparam logic DROP_BIT = (DROP_ON_ERR != 0);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          flag_q;
    logic [10:0]   frame_q;
    logic          p_bad_q, f_bad_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;
    logic          parity_err_q, frame_err_q, overrun_err_q;

    logic new_frame, empty, full, rd_fire, errored, in_store;
    logic push, store_ovr, busy_ovr;

    // Frame edge detect, FIFO status and the STORE-cycle push/overrun decision
    always_comb begin
        new_frame = bus.recieved_flag & ~flag_q;
        empty     = (count_q == '0);
        full      = (count_q == FULL_CNT);
        rd_fire   = bus.rd_en & ~empty;
        errored   = p_bad_q | f_bad_q;
        in_store  = (state_q == S_STORE);
        push      = in_store & ~(errored & DROP_BIT) & (~full | rd_fire);
        store_ovr = in_store & ~(errored & DROP_BIT) & full & ~rd_fire;
        busy_ovr  = new_frame & (state_q != S_WAIT);
        state_d   = state_q;
        case (state_q)
            S_WAIT:  if (new_frame) state_d = S_CHECK;
            S_CHECK: state_d = S_STORE;
            S_STORE: state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    // Controller state, flag history and frame capture/check registers
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            flag_q  <= 1'b0;
            frame_q <= '0;
            p_bad_q <= 1'b0;
            f_bad_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= bus.recieved_flag;
            if (state_q == S_WAIT && new_frame)
                frame_q <= bus.data_parll;
            if (state_q == S_CHECK) begin
                p_bad_q <= (^frame_q[9:1]) != ODD_BIT;
                f_bad_q <= frame_q[0] | ~frame_q[10];
            end
        end
    end

    // FIFO storage; a full FIFO reads the old head while the new byte lands in the same slot
    always_ff @(posedge baud_clk) begin
        if (push)
            mem_q[wr_ptr_q] <= frame_q[8:1];
    end

    // FIFO pointers, occupancy and the read port
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            case ({push, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            parity_err_q  <= (parity_err_q  & ~bus.err_clr) | (in_store & p_bad_q);
            frame_err_q   <= (frame_err_q   & ~bus.err_clr) | (in_store & f_bad_q);
            overrun_err_q <= (overrun_err_q & ~bus.err_clr) | store_ovr | busy_ovr;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.fifo_empty  = empty;
    assign bus.fifo_full   = full;
    assign bus.fifo_count  = count_q;
    assign bus.parity_err  = parity_err_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_err_q;
    assign bus.rx_busy     = bus.active_flag | (state_q != S_WAIT);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        act, rflag, rd_en, err_clr;
    logic [10:0] dp;
    int          total = 0;
    int          passed = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl_if #(.FIFO_DEPTH(4)) if0 ();
    uart_rx_ctrl_if #(.FIFO_DEPTH(4)) if1 ();

    assign if0.active_flag   = act;
    assign if0.recieved_flag = rflag;
    assign if0.data_parll    = dp;
    assign if0.rd_en         = rd_en;
    assign if0.err_clr       = err_clr;
    assign if1.active_flag   = act;
    assign if1.recieved_flag = rflag;
    assign if1.data_parll    = dp;
    assign if1.rd_en         = rd_en;
    assign if1.err_clr       = err_clr;

    uart_rx_ctrl #(.FIFO_DEPTH(4), .PARITY_ODD(0), .DROP_ON_ERR(1)) dut0 (
        .baud_clk (clk),
        .reset    (rst),
        .bus      (if0.slave)
    );

    uart_rx_ctrl #(.FIFO_DEPTH(4), .PARITY_ODD(0), .DROP_ON_ERR(0)) dut1 (
        .baud_clk (clk),
        .reset    (rst),
        .bus      (if1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Well-formed even-parity frame around a data byte
    function automatic logic [10:0] mk(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    // One-cycle frame-complete pulse, then wait out CHECK and STORE
    task automatic send(input logic [10:0] f);
        dp = f;
        rflag = 1'b1;
        tick();
        rflag = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 32'(if0.fifo_count), 32'd0);
        chk({tag, "_empty"}, 32'(if0.fifo_empty), 32'd1);
        chk({tag, "_full"}, 32'(if0.fifo_full), 32'd0);
        chk({tag, "_rdv"}, 32'(if0.rd_valid), 32'd0);
        chk({tag, "_rdd"}, 32'(if0.rd_data), 32'd0);
        chk({tag, "_errs"}, {29'd0, if0.parity_err, if0.frame_err, if0.overrun_err}, 32'd0);
        chk({tag, "_busy"}, 32'(if0.rx_busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; act = 1'b0; rflag = 1'b0; rd_en = 1'b0; err_clr = 1'b0; dp = '0;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b0;
        tick();

        act = 1'b1;
        tick();
        chk("busy_active", 32'(if0.rx_busy), 32'd1);
        act = 1'b0;

        // 1: valid frame 0x482, flag held two cycles
        dp = 11'h482;
        rflag = 1'b1;
        tick();
        chk("t1_busy_check", 32'(if0.rx_busy), 32'd1);
        chk("t1_cnt_k", 32'(if0.fifo_count), 32'd0);
        tick();
        chk("t1_cnt_k1", 32'(if0.fifo_count), 32'd0);
        rflag = 1'b0;
        tick();
        chk("t1_cnt_k2", 32'(if0.fifo_count), 32'd1);
        tick();
        tick();
        chk("t1_single_push", 32'(if0.fifo_count), 32'd1);
        rd();
        chk("t1_rdv", 32'(if0.rd_valid), 32'd1);
        chk("t1_rdd", 32'(if0.rd_data), 32'h41);
        chk("t1_cnt_after_rd", 32'(if0.fifo_count), 32'd0);
        tick();
        chk("t1_rdv_pulse", 32'(if0.rd_valid), 32'd0);
        chk("t1_errs", {29'd0, if0.parity_err, if0.frame_err, if0.overrun_err}, 32'd0);

        // 2: bad parity, dropped in dut0 and kept in dut1
        send(11'h682);
        chk("t2_perr0", 32'(if0.parity_err), 32'd1);
        chk("t2_cnt0", 32'(if0.fifo_count), 32'd0);
        chk("t2_perr1", 32'(if1.parity_err), 32'd1);
        chk("t2_cnt1", 32'(if1.fifo_count), 32'd1);
        rd();
        chk("t2_rdv1", 32'(if1.rd_valid), 32'd1);
        chk("t2_rdd1", 32'(if1.rd_data), 32'h41);
        chk("t2_empty_rd_ignored", 32'(if0.rd_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t2_perr_clr", 32'(if0.parity_err), 32'd0);

        // 3: stop bit 0, then clear coincident with a new framing error
        send(11'h082);
        chk("t3_ferr", 32'(if0.frame_err), 32'd1);
        chk("t3_perr", 32'(if0.parity_err), 32'd0);
        chk("t3_cnt0", 32'(if0.fifo_count), 32'd0);
        chk("t3_cnt1", 32'(if1.fifo_count), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_ferr_clr", 32'(if0.frame_err), 32'd0);
        rd();
        dp = 11'h082;
        rflag = 1'b1;
        tick();
        rflag = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_ferr_wins", 32'(if0.frame_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        rd();

        // 4: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) send(mk(8'(8'h10 + i)));
        chk("t4_full", 32'(if0.fifo_full), 32'd1);
        chk("t4_cnt", 32'(if0.fifo_count), 32'd4);
        chk("t4_ovr", 32'(if0.overrun_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_ovr_clr", 32'(if0.overrun_err), 32'd0);

        // 5: full FIFO, STORE coincides with a read
        dp = mk(8'h55);
        rflag = 1'b1;
        tick();
        rflag = 1'b0;
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t5_rdd", 32'(if0.rd_data), 32'h10);
        chk("t5_cnt", 32'(if0.fifo_count), 32'd4);
        chk("t5_no_ovr", 32'(if0.overrun_err), 32'd0);
        rd();
        chk("t4_rd1", 32'(if0.rd_data), 32'h11);
        rd();
        chk("t4_rd2", 32'(if0.rd_data), 32'h12);
        rd();
        chk("t4_rd3", 32'(if0.rd_data), 32'h13);
        rd();
        chk("t5_rd4", 32'(if0.rd_data), 32'h55);
        chk("t4_empty", 32'(if0.fifo_empty), 32'd1);
        rd();
        chk("t5_empty_rdv", 32'(if0.rd_valid), 32'd0);
        chk("t5_empty_rdd_hold", 32'(if0.rd_data), 32'h55);

        // New frame arriving while the controller is in STORE
        dp = 11'h482;
        rflag = 1'b1;
        tick();
        rflag = 1'b0;
        tick();
        dp = mk(8'h77);
        rflag = 1'b1;
        tick();
        rflag = 1'b0;
        chk("busy_ovr", 32'(if0.overrun_err), 32'd1);
        tick();
        tick();
        chk("busy_ovr_cnt", 32'(if0.fifo_count), 32'd1);

        // 6: reset with two entries queued and a frame in CHECK
        send(11'h482);
        chk("t6_cnt2", 32'(if0.fifo_count), 32'd2);
        dp = 11'h482;
        rflag = 1'b1;
        tick();
        rflag = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6");
        send(mk(8'h5A));
        chk("t6_cnt_after", 32'(if0.fifo_count), 32'd1);
        rd();
        chk("t6_rdd", 32'(if0.rd_data), 32'h5A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
